imem_sync: RTL and testbench
============================

Name: imem_sync

Overview:
- Parametrised, clocked successor to the combinational instruction memory: word-organised ROM/RAM with registered (1-cycle) read.
- Valid/ready fetch handshake with a single-entry response buffer for stalls.
- Program-load write port so test programs are written at run time rather than hard-coded.
- Post-reset clear sweep, plus misaligned / out-of-range fetch faults that return a NOP. Sits between the PC/fetch stage and decode.

Parameters:
XLEN, 32, instruction/PC width in bits
DEPTH, 256, number of instruction words (power of two, >= 2)
AW, $clog2(DEPTH), word-address width (derived localparam, not overridable)
CLEAR_ON_RESET, 1, 1 = zero all words after reset (INIT sweep); 0 = go straight to READY
NOP_INST, 32'h0000_0013, word returned on a faulted fetch (addi x0,x0,0)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  fetch request present
req_ready  out  1  block can accept a fetch this cycle
req_pc  in  XLEN  byte address of the fetch
resp_valid  out  1  resp_inst/resp_fault valid
resp_ready  in  1  consumer accepts the response
resp_inst  out  XLEN  fetched instruction word
resp_fault  out  2  00 ok, 01 misaligned (pc[1:0]!=0), 10 out of range (pc[XLEN-1:2] >= DEPTH)
ld_en  in  1  program-load write strobe
ld_addr  in  AW  word index to write
ld_data  in  XLEN  word to write
busy  out  1  high while in INIT sweep

Behaviour:
- Reset (rst=1 at an edge): resp_valid=0, resp_inst=0, resp_fault=00, req_ready=0. FSM goes to INIT with clear counter=0 if CLEAR_ON_RESET=1, else to READY. busy=1 in INIT. Memory contents are not changed by the reset edge itself.
- FSM states:
  - INIT: each cycle writes 0 to mem[counter]; counter++. After writing DEPTH-1, go to READY the next cycle. Lasts exactly DEPTH cycles. req_ready=0; ld_en ignored.
  - READY: req_ready = !resp_valid | resp_ready.
- Reset mid-INIT or mid-fetch restarts INIT from counter 0 and drops any pending response.
- Fetch accept (req_valid & req_ready at an edge):
  - Next cycle resp_valid=1, with resp_inst/resp_fault computed from req_pc at the accept edge.
  - Latency is exactly 1 cycle. Back-to-back accepts give one response per cycle.
- Fault priority: misaligned (01) over out-of-range (10). Any fault returns resp_inst=NOP_INST. Memory is never read with an out-of-range index.
- Word index = req_pc[AW+1:2]. The range check uses the full req_pc[XLEN-1:2], so there is no wrap-around.
- Stall (resp_valid & !resp_ready): resp_valid, resp_inst and resp_fault hold stable and req_ready=0. The response drops (or is replaced by a newly accepted one) only at an edge where resp_ready=1.
- Without a new accept, resp_valid goes 0 after the consuming edge.
- Load port, READY only:
  - ld_en writes ld_data to mem[ld_addr] at the edge.
  - Same-cycle fetch of the same word returns the OLD contents (read-before-write). The new value is visible from the next accepted fetch.
  - Loads are allowed regardless of req/resp handshake state.
- No combinational path from req_* or ld_* to resp_*. req_ready depends combinationally only on FSM state, resp_valid and resp_ready.

Test Plan:
1. Reset with DEPTH=256, CLEAR_ON_RESET=1 -> busy=1 and req_ready=0 for exactly 256 cycles, then READY. Fetch pc=0x3FC -> resp_inst=0, fault=00, one cycle after accept.
2. Load mem[1]=0x40418533 (sub), then fetch pc=0x004 with resp_ready=1 -> next cycle resp_valid=1, resp_inst=0x40418533. Back-to-back fetches 0x000/0x004 stream one response per cycle.
3. Same edge: ld_en (ld_addr=2, ld_data=0x0020C1B3) and accepted fetch pc=0x008 holding 0x11111111 -> response 0x11111111. Refetch -> 0x0020C1B3.
4. Fetch pc=0x006 -> fault=01, inst=0x00000013. Fetch pc=0x400 (DEPTH=256) -> fault=10, inst=0x00000013. Fetch pc=0x402 -> fault=01.
5. Accept fetch, hold resp_ready=0 for 3 cycles -> resp_* stable and req_ready=0 throughout. Raise resp_ready with req_valid=1 -> new request accepted on that edge, new response next cycle.
6. Assert rst during INIT (counter≈100) and during a stalled response -> resp_valid=0 next cycle, INIT restarts at 0 and runs a full 256 cycles. With CLEAR_ON_RESET=0 -> req_ready=1 the cycle after reset.

Source files
------------

// File: rtl/imem_sync.sv
// ============================================================================
// Module      : imem_sync
// Description : Word-organised instruction memory with a registered 1-cycle
//               read, a valid/ready fetch handshake, a program-load port, a
//               post-reset clear sweep and fetch-fault reporting.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_sync #(
    parameter int              XLEN           = 32,
    parameter int              DEPTH          = 256,
    parameter bit              CLEAR_ON_RESET = 1'b1,
    parameter logic [XLEN-1:0] NOP_INST       = 32'h0000_0013,
    localparam int             AW             = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_pc,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_inst,
    output logic [1:0]      resp_fault,
    input  logic            ld_en,
    input  logic [AW-1:0]   ld_addr,
    input  logic [XLEN-1:0] ld_data,
    output logic            busy
);

    localparam logic          c_ST_INIT   = 1'b0;
    localparam logic          c_ST_READY  = 1'b1;
    localparam logic [AW-1:0] c_LAST      = AW'(DEPTH - 1);
    localparam logic [1:0]    c_FLT_OK    = 2'b00;
    localparam logic [1:0]    c_FLT_MISAL = 2'b01;
    localparam logic [1:0]    c_FLT_RANGE = 2'b10;

    logic [XLEN-1:0] r_mem [DEPTH];
    logic            r_state;
    logic [AW-1:0]   r_cnt;
    logic            r_valid;
    logic [XLEN-1:0] r_inst;
    logic [1:0]      r_fault;

    logic            w_misal;
    logic            w_oor;
    logic            w_accept;
    logic [AW-1:0]   w_idx;

    // DEPTH is a power of two, so any set bit above the index field is out of range
    assign w_misal  = |req_pc[1:0];
    assign w_oor    = |req_pc[XLEN-1:AW+2];
    assign w_idx    = req_pc[AW+1:2];

    assign req_ready  = (r_state == c_ST_READY) & (~r_valid | resp_ready);
    assign w_accept   = req_valid & req_ready;
    assign busy       = (r_state == c_ST_INIT);
    assign resp_valid = r_valid;
    assign resp_inst  = r_inst;
    assign resp_fault = r_fault;

    // Storage has no reset; the sweep, not the reset edge, clears it
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == c_ST_INIT) begin
                r_mem[r_cnt] <= '0;
            end else if (ld_en) begin
                r_mem[ld_addr] <= ld_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CLEAR_ON_RESET ? c_ST_INIT : c_ST_READY;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_inst  <= '0;
            r_fault <= c_FLT_OK;
        end else begin
            if (r_state == c_ST_INIT) begin
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == c_LAST) begin
                    r_state <= c_ST_READY;
                end
            end

            // Read-before-write: a same-edge load is not seen by this read
            if (w_accept) begin
                r_valid <= 1'b1;
                if (w_misal) begin
                    r_inst  <= NOP_INST;
                    r_fault <= c_FLT_MISAL;
                end else if (w_oor) begin
                    r_inst  <= NOP_INST;
                    r_fault <= c_FLT_RANGE;
                end else begin
                    r_inst  <= r_mem[w_idx];
                    r_fault <= c_FLT_OK;
                end
            end else if (resp_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_imem_sync.sv
// ============================================================================
// Module      : tb_imem_sync
// Description : Self-checking bench for imem_sync: directed vectors, stall and
//               reset sequences, and a randomized run against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_sync;

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_inst;
    logic [1:0]  resp_fault;
    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [31:0] ld_data;
    logic        busy;

    logic        rst2;
    logic        req_valid2;
    logic        req_ready2;
    logic [31:0] req_pc2;
    logic        resp_valid2;
    logic        resp_ready2;
    logic [31:0] resp_inst2;
    logic [1:0]  resp_fault2;
    logic        ld_en2;
    logic [3:0]  ld_addr2;
    logic [31:0] ld_data2;
    logic        busy2;

    int n_cmp = 0;
    int n_bad = 0;

    imem_sync #(.XLEN(32), .DEPTH(256), .CLEAR_ON_RESET(1'b1), .NOP_INST(c_NOP)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_pc(req_pc), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_inst(resp_inst), .resp_fault(resp_fault), .ld_en(ld_en),
        .ld_addr(ld_addr), .ld_data(ld_data), .busy(busy)
    );

    imem_sync #(.XLEN(32), .DEPTH(16), .CLEAR_ON_RESET(1'b0), .NOP_INST(c_NOP)) u_dut2 (
        .clk(clk), .rst(rst2), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_pc(req_pc2), .resp_valid(resp_valid2), .resp_ready(resp_ready2),
        .resp_inst(resp_inst2), .resp_fault(resp_fault2), .ld_en(ld_en2),
        .ld_addr(ld_addr2), .ld_data(ld_data2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [1:0]  fault;
    } vec_t;

    vec_t        vecs [9];
    logic [31:0] model_mem [256];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Outputs are sampled on the negedge that follows the reset edge
    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_inst", resp_inst, 32'd0);
        chk("rst_resp_fault", 32'(resp_fault), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
    endtask

    task automatic wait_init();
        int n = 0;
        while (busy && n < 1000) begin
            if (req_ready) n = 2000;
            else n++;
            tick();
        end
        chk("init_cycles", 32'(n), 32'd256);
        chk("init_req_ready", 32'(req_ready), 32'd1);
    endtask

    task automatic load(input logic [7:0] a, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic fetch(input string name, input logic [31:0] pc,
                         input logic [31:0] ei, input logic [1:0] ef);
        req_valid = 1'b1; req_pc = pc; resp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        chk({name, "_valid"}, 32'(resp_valid), 32'd1);
        chk({name, "_inst"}, resp_inst, ei);
        chk({name, "_fault"}, 32'(resp_fault), 32'(ef));
        tick();
    endtask

    function automatic logic [33:0] ref_fetch(input logic [31:0] pc);
        if (pc % 4 != 0)        return {2'b01, c_NOP};
        else if (pc / 4 >= 256) return {2'b10, c_NOP};
        else                    return {2'b00, model_mem[pc / 4]};
    endfunction

    initial begin
        logic        mv, rv, rr, ld, mready;
        logic [31:0] mi, pc, d;
        logic [1:0]  mf;
        logic [7:0]  a;
        logic [33:0] r;
        int          sel;

        rst = 1'b1; req_valid = 1'b0; req_pc = '0; resp_ready = 1'b0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        rst2 = 1'b1; req_valid2 = 1'b0; req_pc2 = '0; resp_ready2 = 1'b0;
        ld_en2 = 1'b0; ld_addr2 = '0; ld_data2 = '0;
        tick(); tick();

        // Power-up sweep and cleared top word
        do_reset();
        wait_init();
        fetch("clear_top", 32'h3FC, 32'h0, 2'b00);

        load(8'd0, 32'h0050_0093);
        load(8'd1, 32'h4041_8533);
        load(8'd2, 32'h1111_1111);
        load(8'd255, 32'hDEAD_BEEF);
        fetch("load_word1", 32'h004, 32'h4041_8533, 2'b00);

        vecs[0] = '{32'h0000_0000, 32'h0050_0093, 2'b00};
        vecs[1] = '{32'h0000_0004, 32'h4041_8533, 2'b00};
        vecs[2] = '{32'h0000_0006, c_NOP,         2'b01};
        vecs[3] = '{32'h0000_0400, c_NOP,         2'b10};
        vecs[4] = '{32'h0000_0402, c_NOP,         2'b01};
        vecs[5] = '{32'h0000_03FC, 32'hDEAD_BEEF, 2'b00};
        vecs[6] = '{32'h0000_0008, 32'h1111_1111, 2'b00};
        vecs[7] = '{32'hFFFF_FFFC, c_NOP,         2'b10};
        vecs[8] = '{32'h0000_0001, c_NOP,         2'b01};
        for (int i = 0; i < 9; i++) begin
            req_valid = 1'b1; req_pc = vecs[i].pc; resp_ready = 1'b1;
            tick();
            chk($sformatf("vec%0d_valid", i), 32'(resp_valid), 32'd1);
            chk($sformatf("vec%0d_inst", i), resp_inst, vecs[i].inst);
            chk($sformatf("vec%0d_fault", i), 32'(resp_fault), 32'(vecs[i].fault));
        end
        req_valid = 1'b0;
        tick();
        chk("stream_drain", 32'(resp_valid), 32'd0);

        // Load and fetch of the same word on one edge
        ld_en = 1'b1; ld_addr = 8'd2; ld_data = 32'h0020_C1B3;
        req_valid = 1'b1; req_pc = 32'h008; resp_ready = 1'b1;
        tick();
        ld_en = 1'b0; req_valid = 1'b0;
        chk("rbw_old", resp_inst, 32'h1111_1111);
        tick();
        fetch("rbw_new", 32'h008, 32'h0020_C1B3, 2'b00);

        // Stall for three cycles, then replace on the consuming edge
        req_valid = 1'b1; req_pc = 32'h004; resp_ready = 1'b0;
        tick();
        req_pc = 32'h000;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("stall%0d_valid", i), 32'(resp_valid), 32'd1);
            chk($sformatf("stall%0d_inst", i), resp_inst, 32'h4041_8533);
            chk($sformatf("stall%0d_fault", i), 32'(resp_fault), 32'd0);
            chk($sformatf("stall%0d_req_ready", i), 32'(req_ready), 32'd0);
            tick();
        end
        resp_ready = 1'b1;
        #1;
        chk("unstall_req_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        chk("unstall_valid", 32'(resp_valid), 32'd1);
        chk("unstall_inst", resp_inst, 32'h0050_0093);
        tick();
        chk("unstall_drop", 32'(resp_valid), 32'd0);

        // Reset in the middle of the sweep restarts it from zero
        do_reset();
        for (int i = 0; i < 100; i++) tick();
        do_reset();
        wait_init();

        // Reset while a response is stalled drops it
        load(8'd3, 32'h00A0_0113);
        req_valid = 1'b1; req_pc = 32'h00C; resp_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        chk("pre_rst_stall", 32'(resp_valid), 32'd1);
        tick();
        do_reset();
        wait_init();
        fetch("cleared_after_rst", 32'h00C, 32'h0, 2'b00);

        // Randomized run against the reference model
        for (int i = 0; i < 256; i++) model_mem[i] = 32'h0;
        mv = 1'b0; mi = '0; mf = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            chk("rnd_valid", 32'(resp_valid), 32'(mv));
            if (mv) begin
                chk("rnd_inst", resp_inst, mi);
                chk("rnd_fault", 32'(resp_fault), 32'(mf));
            end
            rv  = 1'($urandom_range(0, 1));
            rr  = ($urandom_range(0, 3) != 0);
            ld  = ($urandom_range(0, 2) == 0);
            sel = $urandom_range(0, 9);
            if (sel < 6)      pc = 32'($urandom_range(0, 15)) * 4;
            else if (sel < 8) pc = 32'($urandom_range(0, 63));
            else              pc = $urandom;
            a = 8'($urandom_range(0, 15));
            d = $urandom;
            req_valid = rv; req_pc = pc; resp_ready = rr;
            ld_en = ld; ld_addr = a; ld_data = d;
            #1;
            mready = !mv || rr;
            chk("rnd_req_ready", 32'(req_ready), 32'(mready));
            if (rv && mready) begin
                r = ref_fetch(pc);
                mv = 1'b1; mf = r[33:32]; mi = r[31:0];
            end else if (rr) begin
                mv = 1'b0;
            end
            if (ld) model_mem[a] = d;
            tick();
        end
        req_valid = 1'b0; ld_en = 1'b0; resp_ready = 1'b1;
        tick();

        // No-sweep variant is ready right after reset
        rst2 = 1'b1;
        tick();
        rst2 = 1'b0;
        chk("noclr_req_ready", 32'(req_ready2), 32'd1);
        chk("noclr_busy", 32'(busy2), 32'd0);
        req_valid2 = 1'b1; req_pc2 = 32'h40; resp_ready2 = 1'b1;
        tick();
        req_valid2 = 1'b0;
        chk("noclr_oor_fault", 32'(resp_fault2), 32'd2);
        chk("noclr_oor_inst", resp_inst2, c_NOP);
        req_valid2 = 1'b1; req_pc2 = 32'h3C;
        tick();
        req_valid2 = 1'b0;
        chk("noclr_top_fault", 32'(resp_fault2), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
